// File: rtl/cmos_capture_ctrl.sv
// Frame-level capture sequencer on the sensor pixel clock: waits for a frame boundary,
// skips settling frames, gates whole frames into the pixel packer and checks frame geometry.
module cmos_capture_ctrl #(
   parameter int BYTES_PER_LINE = 2560,
   parameter int LINES          = 720,
   parameter int SKIP_FRAMES    = 2
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_data,
   input  logic        capture_start,
   input  logic        capture_stop,
   input  logic        cfg_continuous,
   output logic        de_o,
   output logic [7:0]  pdata_o,
   output logic        frame_start,
   output logic        frame_done,
   output logic        busy,
   output logic        size_err,
   output logic [10:0] last_lines
);

   localparam logic [11:0] BPL      = 12'(BYTES_PER_LINE);
   localparam logic [10:0] NLINES   = 11'(LINES);
   localparam logic [3:0]  NSKIP    = 4'(SKIP_FRAMES);
   localparam logic [11:0] BYTE_MAX = 12'hFFF;
   localparam logic [10:0] LINE_MAX = 11'h7FF;

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ARM, ST_ACTIVE} state_t;

   state_t      state_q;
   logic        vs_q, hr_q;
   logic        cont_q, stop_pend_q;
   logic [3:0]  skip_q;
   logic [11:0] byte_q;
   logic [10:0] line_q;
   logic        de_q, fs_q, fd_q, err_q;
   logic [7:0]  pdata_q;
   logic [10:0] last_q;

   logic vs_rise, vs_fall, hr_fall;

   assign vs_rise = cmos_vsync & ~vs_q;
   assign vs_fall = ~cmos_vsync & vs_q;
   assign hr_fall = ~cmos_href & hr_q;

   // NOTE: every register lives in this one clocked block and is written with <=, so all
   // right-hand sides see the pre-edge values and no ordering hazards or latches can arise.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vs_q        <= 1'b0;
         hr_q        <= 1'b0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         skip_q      <= '0;
         byte_q      <= '0;
         line_q      <= '0;
         de_q        <= 1'b0;
         fs_q        <= 1'b0;
         fd_q        <= 1'b0;
         err_q       <= 1'b0;
         pdata_q     <= '0;
         last_q      <= '0;
      end else begin
         vs_q    <= cmos_vsync;
         hr_q    <= cmos_href;
         pdata_q <= cmos_data;
         fs_q    <= 1'b0;
         fd_q    <= 1'b0;
         // Oversized lines and frames are dropped here but still counted for the check below.
         de_q    <= cmos_href && (state_q == ST_ACTIVE) && (byte_q < BPL) && (line_q < NLINES);

         case (state_q)
            ST_IDLE: begin
               if (capture_start && !capture_stop) begin
                  state_q     <= ST_SYNC;
                  cont_q      <= cfg_continuous;
                  stop_pend_q <= 1'b0;
                  skip_q      <= '0;
                  err_q       <= 1'b0;
               end
            end

            ST_SYNC: begin
               if (capture_stop) begin
                  state_q <= ST_IDLE;
               end else if (vs_rise) begin
                  if (skip_q == NSKIP) state_q <= ST_ARM;
                  else                 skip_q  <= skip_q + 4'd1;
               end
            end

            ST_ARM: begin
               if (capture_stop) begin
                  state_q <= ST_IDLE;
               end else if (vs_fall) begin
                  state_q <= ST_ACTIVE;
                  fs_q    <= 1'b1;
                  line_q  <= '0;
                  byte_q  <= '0;
               end
            end

            ST_ACTIVE: begin
               if (!cmos_href)            byte_q <= '0;
               else if (byte_q != BYTE_MAX) byte_q <= byte_q + 12'd1;

               if (capture_stop) stop_pend_q <= 1'b1;

               if (hr_fall) begin
                  if (line_q != LINE_MAX) line_q <= line_q + 11'd1;
                  if (byte_q != BPL)      err_q  <= 1'b1;
               end

               // A stop arriving on the closing edge still lets this frame finish.
               if (vs_rise) begin
                  fd_q   <= 1'b1;
                  last_q <= line_q;
                  if (line_q != NLINES) err_q <= 1'b1;
                  if (cont_q && !stop_pend_q && !capture_stop) state_q <= ST_ARM;
                  else                                         state_q <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign de_o        = de_q;
   assign pdata_o     = pdata_q;
   assign frame_start = fs_q;
   assign frame_done  = fd_q;
   assign busy        = (state_q != ST_IDLE);
   assign size_err    = err_q;
   assign last_lines  = last_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Directed bench for cmos_capture_ctrl with a reduced 4-line x 8-byte frame geometry.
module tb_cmos_capture_ctrl;

   localparam int BPL   = 8;
   localparam int NL    = 4;
   localparam int NSKIP = 2;

   logic        pclk = 1'b0;
   logic        rst;
   logic        cmos_vsync, cmos_href;
   logic [7:0]  cmos_data;
   logic        capture_start, capture_stop, cfg_continuous;

   logic        de_o, frame_start, frame_done, busy, size_err;
   logic [7:0]  pdata_o;
   logic [10:0] last_lines;

   logic        de_z, fs_z, fd_z, busy_z, err_z;
   logic [7:0]  pdata_z;
   logic [10:0] last_z;

   int n_checks = 0;
   int n_fail   = 0;
   int de_cnt = 0, fs_cnt = 0, fd_cnt = 0, de_cnt0 = 0, fd_cnt0 = 0;

   always #5 pclk = ~pclk;

   cmos_capture_ctrl #(.BYTES_PER_LINE(BPL), .LINES(NL), .SKIP_FRAMES(NSKIP)) u_dut (
      .pclk(pclk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
      .cmos_data(cmos_data), .capture_start(capture_start), .capture_stop(capture_stop),
      .cfg_continuous(cfg_continuous), .de_o(de_o), .pdata_o(pdata_o),
      .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
      .size_err(size_err), .last_lines(last_lines)
   );

   cmos_capture_ctrl #(.BYTES_PER_LINE(BPL), .LINES(NL), .SKIP_FRAMES(0)) u_dut0 (
      .pclk(pclk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
      .cmos_data(cmos_data), .capture_start(capture_start), .capture_stop(capture_stop),
      .cfg_continuous(cfg_continuous), .de_o(de_z), .pdata_o(pdata_z),
      .frame_start(fs_z), .frame_done(fd_z), .busy(busy_z),
      .size_err(err_z), .last_lines(last_z)
   );

   // Pulse counters sample 1 ns after each active edge.
   always @(posedge pclk) begin
      #1;
      if (de_o)        de_cnt++;
      if (frame_start) fs_cnt++;
      if (frame_done)  fd_cnt++;
      if (de_z)        de_cnt0++;
      if (fd_z)        fd_cnt0++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge pclk);
   endtask

   task automatic clear_counts();
      de_cnt = 0; fs_cnt = 0; fd_cnt = 0; de_cnt0 = 0; fd_cnt0 = 0;
   endtask

   task automatic pulse_start(input logic cont);
      capture_start  = 1'b1;
      cfg_continuous = cont;
      step();
      capture_start  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_counts();
   endtask

   task automatic send_line(input int l, input int len, input logic stop_here);
      capture_stop = stop_here;
      for (int b = 0; b < len; b++) begin
         cmos_href = 1'b1;
         cmos_data = 8'(l * 16 + b + 1);
         step();
         capture_stop = 1'b0;
      end
      cmos_href = 1'b0;
      repeat (3) step();
   endtask

   task automatic vblank();
      cmos_vsync = 1'b1;
      repeat (4) step();
      cmos_vsync = 1'b0;
      repeat (3) step();
   endtask

   // One frame: vertical blanking, active lines, short tail. bad_line gets bad_len bytes.
   task automatic run_frame(input int n_lines, input int bad_line, input int bad_len,
                            input int stop_line);
      vblank();
      for (int l = 0; l < n_lines; l++)
         send_line(l, (l == bad_line) ? bad_len : BPL, l == stop_line);
      repeat (2) step();
   endtask

   typedef struct {
      int n_lines;
      int bad_line;
      int bad_len;
      int exp_de;
      int exp_last;
      int exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{n_lines: 4, bad_line: -1, bad_len: 8,  exp_de: 32, exp_last: 4, exp_err: 0};
      vecs[1] = '{n_lines: 4, bad_line: 1,  bad_len: 10, exp_de: 32, exp_last: 4, exp_err: 1};
      vecs[2] = '{n_lines: 5, bad_line: -1, bad_len: 8,  exp_de: 32, exp_last: 5, exp_err: 1};
      vecs[3] = '{n_lines: 3, bad_line: -1, bad_len: 8,  exp_de: 24, exp_last: 3, exp_err: 1};
      vecs[4] = '{n_lines: 4, bad_line: 2,  bad_len: 6,  exp_de: 30, exp_last: 4, exp_err: 1};

      rst = 1'b1; cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_data = 8'hA5;
      capture_start = 1'b0; capture_stop = 1'b0; cfg_continuous = 1'b0;
      repeat (3) step();
      check("reset de_o", int'(de_o), 0);
      check("reset pdata_o", int'(pdata_o), 0);
      check("reset busy", int'(busy), 0);
      check("reset frame_start", int'(frame_start), 0);
      check("reset frame_done", int'(frame_done), 0);
      check("reset size_err", int'(size_err), 0);
      check("reset last_lines", int'(last_lines), 0);
      rst = 1'b0;
      cmos_data = 8'h00;
      step();
      clear_counts();

      // Single-frame captures with varied geometry; no reset between, so each start
      // must clear the sticky error left by the previous vector.
      for (int i = 0; i < 5; i++) begin
         clear_counts();
         pulse_start(1'b0);
         check($sformatf("v%0d busy after start", i), int'(busy), 1);
         check($sformatf("v%0d size_err cleared", i), int'(size_err), 0);
         for (int f = 0; f < NSKIP + 1; f++)
            run_frame(vecs[i].n_lines, vecs[i].bad_line, vecs[i].bad_len, -1);
         check($sformatf("v%0d de count", i), de_cnt, vecs[i].exp_de);
         check($sformatf("v%0d frame_start count", i), fs_cnt, 1);
         check($sformatf("v%0d busy before close", i), int'(busy), 1);
         run_frame(NL, -1, BPL, -1);
         check($sformatf("v%0d frame_done count", i), fd_cnt, 1);
         check($sformatf("v%0d last_lines", i), int'(last_lines), vecs[i].exp_last);
         check($sformatf("v%0d size_err", i), int'(size_err), vecs[i].exp_err);
         check($sformatf("v%0d busy at end", i), int'(busy), 0);
         check($sformatf("v%0d de after close", i), de_cnt, vecs[i].exp_de);
      end

      // Continuous mode: three frames, stop requested midway through the third.
      clear_counts();
      pulse_start(1'b1);
      for (int f = 0; f < NSKIP; f++) run_frame(NL, -1, BPL, -1);
      check("cont skip de", de_cnt, 0);
      run_frame(NL, -1, BPL, -1);
      run_frame(NL, -1, BPL, -1);
      run_frame(NL, -1, BPL, 2);
      check("cont busy after stop frame", int'(busy), 1);
      run_frame(NL, -1, BPL, -1);
      check("cont de count", de_cnt, 96);
      check("cont frame_start count", fs_cnt, 3);
      check("cont frame_done count", fd_cnt, 3);
      check("cont busy after stop", int'(busy), 0);
      check("cont size_err", int'(size_err), 0);
      run_frame(NL, -1, BPL, -1);
      check("cont de after idle frame", de_cnt, 96);

      // Stop during a skip frame.
      clear_counts();
      pulse_start(1'b0);
      vblank();
      check("sync busy before stop", int'(busy), 1);
      capture_stop = 1'b1;
      step();
      capture_stop = 1'b0;
      check("sync busy after stop", int'(busy), 0);
      for (int f = 0; f < 4; f++) run_frame(NL, -1, BPL, -1);
      check("sync frame_start count", fs_cnt, 0);
      check("sync de count", de_cnt, 0);

      // Reset while a delivered line is in progress.
      clear_counts();
      pulse_start(1'b0);
      for (int f = 0; f < NSKIP; f++) run_frame(NL, -1, BPL, -1);
      vblank();
      cmos_href = 1'b1;
      cmos_data = 8'h3C;
      repeat (3) step();
      check("rst pre de_o", int'(de_o), 1);
      rst = 1'b1;
      step();
      check("rst de_o", int'(de_o), 0);
      check("rst pdata_o", int'(pdata_o), 0);
      check("rst busy", int'(busy), 0);
      check("rst last_lines", int'(last_lines), 0);
      check("rst frame_start", int'(frame_start), 0);
      rst = 1'b0;
      clear_counts();
      repeat (4) step();
      cmos_href = 1'b0;
      repeat (3) step();
      for (int l = 1; l < NL; l++) send_line(l, BPL, 1'b0);
      run_frame(NL, -1, BPL, -1);
      run_frame(NL, -1, BPL, -1);
      check("rst frame_done count", fd_cnt, 0);
      check("rst de count", de_cnt, 0);

      // Start in the middle of a line on the zero-skip instance.
      do_reset();
      vblank();
      cmos_href = 1'b1;
      for (int b = 0; b < 3; b++) begin
         cmos_data = 8'(b + 1);
         step();
      end
      capture_start  = 1'b1;
      cfg_continuous = 1'b0;
      for (int b = 3; b < BPL; b++) begin
         cmos_data = 8'(b + 1);
         step();
         capture_start = 1'b0;
      end
      cmos_href = 1'b0;
      repeat (3) step();
      for (int l = 1; l < NL; l++) send_line(l, BPL, 1'b0);
      check("mid busy", int'(busy_z), 1);
      check("mid de before boundary", de_cnt0, 0);
      run_frame(NL, -1, BPL, -1);
      check("mid de delivered", de_cnt0, BPL * NL);
      run_frame(NL, -1, BPL, -1);
      check("mid frame_done count", fd_cnt0, 1);
      check("mid de after close", de_cnt0, BPL * NL);
      check("mid last_lines", int'(last_z), NL);
      check("mid size_err", int'(err_z), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
